// File: rtl/program_memory_loader_pkg.sv
// Shared types, constants and CRC helpers for the boot-time program memory loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package program_memory_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_FAIL  = 3'd6
    } pml_state_t;

    localparam logic [7:0]  SPI_READ_OP     = 8'h03;
    localparam logic [31:0] CRC32_POLY      = 32'h04C11DB7;
    // Bit-reversed CRC32_POLY: the reflected CRC is computed LSB first.
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

    // Advance a reflected CRC-32 by one byte.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    // Reverse byte order: flash delivers byte0 first, image words are little-endian.
    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/pml_spi_shifter.sv
// SPI mode-0 engine: SPI_DIV clock divider plus a 32-bit shift register that sends MSB first and receives at once.
// Latency: 32 bits * 2*SPI_DIV clk per word; word_done_o pulses in the cycle of the 32nd sclk falling edge.
// Backpressure: none; runs only while en_i is high and freezes with sclk low when en_i drops after a word.
module pml_spi_shifter #(
    parameter int SPI_DIV = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic [31:0] load_dat_i,
    input  logic        en_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        word_done_o,
    output logic [31:0] shift_o
);

    localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [4:0]       bit_q;
    logic             sclk_q;
    logic             samp_q;
    logic [31:0]      sr_q;
    logic             half_end;

    assign half_end    = en_i && (div_q == DIV_LAST);
    assign word_done_o = half_end && sclk_q && (bit_q == 5'd31);
    assign sclk_o      = sclk_q;
    assign mosi_o      = sr_q[31];
    assign shift_o     = sr_q;

    // Divider and shifter: sample miso on sclk rise, shift on sclk fall so mosi changes on the falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            samp_q <= 1'b0;
            sr_q   <= '0;
        end else if (load_i) begin
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            sr_q   <= load_dat_i;
        end else if (en_i) begin
            if (half_end) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    samp_q <= miso_i;
                end else begin
                    sr_q  <= {sr_q[30:0], samp_q};
                    bit_q <= bit_q + 5'd1;
                end
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/program_memory_loader.sv
// Boot copier: streams NUM_WORDS words from SPI flash (READ 0x03) into program memory, holding the CPU in reset until done.
// Latency: 1 + 64*SPI_DIV clk setup, then 64*SPI_DIV + 1 clk per word; optional CRC word via PROGMEM_LOADER_CRC_EN.
// Backpressure: none; program memory accepts a write every cycle, start is ignored while busy.
import program_memory_loader_pkg::*;

module program_memory_loader #(
    parameter int          NUM_WORDS  = 8192,
    parameter int          ADDR_W     = 13,
    parameter logic [23:0] FLASH_BASE = 24'h100000,
    parameter int          SPI_DIV    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic              cpu_reset_req,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_END = CNT_W'(NUM_WORDS);

    pml_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cs_n_q, cs_n_d;

    logic             sh_load;
    logic             sh_en;
    logic             sh_mosi;
    logic             sh_done;
    logic [31:0]      sh_word;
    logic             wr_act;

    pml_spi_shifter #(
        .SPI_DIV (SPI_DIV)
    ) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load_i      (sh_load),
        .load_dat_i  ({SPI_READ_OP, FLASH_BASE}),
        .en_i        (sh_en),
        .miso_i      (spi_miso),
        .sclk_o      (spi_sclk),
        .mosi_o      (sh_mosi),
        .word_done_o (sh_done),
        .shift_o     (sh_word)
    );

    assign cnt_inc = cnt_q + 1'b1;

`ifdef PROGMEM_LOADER_CRC_EN
    logic [31:0] crc_q, crc_d;
    logic        chk_last_q, chk_last_d;
    logic [31:0] crc_word;

    // Image bytes enter the CRC in flash order: byte0 sits in the top byte of the shifter.
    assign crc_word = crc32_next(crc32_next(crc32_next(crc32_next(crc_q,
                          sh_word[31:24]), sh_word[23:16]), sh_word[15:8]), sh_word[7:0]);

    // CRC accumulator and the flag marking the compare cycle after the CRC word lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q      <= CRC32_INIT;
            chk_last_q <= 1'b0;
        end else begin
            crc_q      <= crc_d;
            chk_last_q <= chk_last_d;
        end
    end
`endif

    // State, word counter and chip select registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_n_q  <= cs_n_d;
        end
    end

    // Next-state logic: one flash READ covers the whole image, so cs_n stays low until the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_n_d  = cs_n_q;
        sh_load = 1'b0;
        sh_en   = 1'b0;
`ifdef PROGMEM_LOADER_CRC_EN
        crc_d      = crc_q;
        chk_last_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                sh_load = 1'b1;
                cs_n_d  = 1'b0;
                cnt_d   = '0;
`ifdef PROGMEM_LOADER_CRC_EN
                crc_d   = CRC32_INIT;
`endif
                state_d = ST_CMD;
            end
            ST_CMD: begin
                sh_en = 1'b1;
                if (sh_done) state_d = ST_DATA;
            end
            ST_DATA: begin
                sh_en = 1'b1;
                if (sh_done) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                cnt_d = cnt_inc;
`ifdef PROGMEM_LOADER_CRC_EN
                crc_d = crc_word;
`endif
                if (cnt_inc < CNT_END) begin
                    state_d = ST_DATA;
                end else begin
`ifdef PROGMEM_LOADER_CRC_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
                    cs_n_d  = 1'b1;
`endif
                end
            end
`ifdef PROGMEM_LOADER_CRC_EN
            ST_CHECK: begin
                // Shift in the CRC word, then compare once it has settled in the shifter.
                if (chk_last_q) begin
                    cs_n_d  = 1'b1;
                    state_d = (bswap32(sh_word) == ~crc_q) ? ST_DONE : ST_FAIL;
                end else begin
                    sh_en = 1'b1;
                    if (sh_done) chk_last_d = 1'b1;
                end
            end
`endif
            ST_DONE, ST_FAIL: begin
                if (start) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cs_n_d  = 1'b1;
            end
        endcase
    end

    assign wr_act         = (state_q == ST_WRITE);
    assign avm_write      = wr_act;
    assign avm_chipselect = wr_act;
    assign avm_byteenable = wr_act ? 4'hF : 4'h0;
    assign avm_address    = wr_act ? cnt_q[ADDR_W-1:0] : '0;
    assign avm_writedata  = wr_act ? bswap32(sh_word) : 32'h0;

    assign spi_cs_n      = cs_n_q;
    assign spi_mosi      = (state_q == ST_CMD) ? sh_mosi : 1'b0;
    assign busy          = (state_q != ST_DONE) && (state_q != ST_FAIL);
    assign done          = (state_q == ST_DONE);
    assign cpu_reset_req = (state_q != ST_DONE);
`ifdef PROGMEM_LOADER_CRC_EN
    assign error         = (state_q == ST_FAIL);
`else
    assign error         = 1'b0;
`endif

endmodule
